// File: rtl/vdp_pkg.sv
// Shared constants and types for the VDP CPU-side front end.
package vdp_pkg;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

    localparam logic [1:0] MODE_TEXT = 2'd0;
    localparam logic [1:0] MODE_G1   = 2'd1;
    localparam logic [1:0] MODE_G2   = 2'd2;
    localparam logic [1:0] MODE_MC   = 2'd3;

    localparam int ST_F  = 7;
    localparam int ST_5S = 6;
    localparam int ST_C  = 5;

    // Second control byte: bit 7 selects a register write, otherwise [7:6] picks the address op.
    localparam int         CTL_REG_BIT    = 7;
    localparam logic [1:0] CTL_OP_VRAM_RD = 2'b00;
    localparam logic [1:0] CTL_OP_VRAM_WR = 2'b01;

    typedef enum logic [1:0] {
        ACC_IDLE       = 2'd0,
        ACC_RD_ISSUE   = 2'd1,
        ACC_RD_CAPTURE = 2'd2,
        ACC_WR         = 2'd3
    } acc_state_t;

endpackage

// File: rtl/vdp_vram_access.sv
// VRAM access sequencer: owns the address counter, the read-ahead buffer and
// the one-at-a-time read/write FSM towards the video block's CPU port.
module vdp_vram_access
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 14
)
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              i_start_rd,
    input  logic              i_start_wr,
    input  logic              i_load_addr,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic [7:0]        i_wr_data,
    input  logic [7:0]        i_vram_din,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic              o_vram_wr,
    output logic              o_vram_rd,
    output logic [7:0]        o_vram_dout,
    output logic [7:0]        o_rd_buf,
    output logic              o_busy,
    output logic [1:0]        o_state
);

    acc_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_vram_wr;
    logic              r_vram_rd;
    logic [7:0]        r_vram_dout;
    logic [7:0]        r_rd_buf;
    logic              r_busy;

    // Requests are only honoured in IDLE; the front end never issues them otherwise.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= ACC_IDLE;
            r_addr      <= '0;
            r_vram_wr   <= 1'b0;
            r_vram_rd   <= 1'b0;
            r_vram_dout <= '0;
            r_rd_buf    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ACC_IDLE: begin
                    if (i_start_wr) begin
                        r_state     <= ACC_WR;
                        r_vram_wr   <= 1'b1;
                        r_vram_dout <= i_wr_data;
                        r_rd_buf    <= i_wr_data;
                        r_busy      <= 1'b1;
                    end else begin
                        if (i_load_addr) begin
                            r_addr <= i_load_val;
                        end
                        if (i_start_rd) begin
                            r_state   <= ACC_RD_ISSUE;
                            r_vram_rd <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                ACC_RD_ISSUE: begin
                    r_vram_rd <= 1'b0;
                    r_state   <= ACC_RD_CAPTURE;
                end
                ACC_RD_CAPTURE: begin
                    r_rd_buf <= i_vram_din;
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_state  <= ACC_IDLE;
                    r_busy   <= 1'b0;
                end
                ACC_WR: begin
                    r_vram_wr <= 1'b0;
                    r_addr    <= r_addr + ADDR_W'(1);
                    r_state   <= ACC_IDLE;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state <= ACC_IDLE;
                end
            endcase
        end
    end

    assign o_vram_addr = r_addr;
    assign o_vram_wr   = r_vram_wr;
    assign o_vram_rd   = r_vram_rd;
    assign o_vram_dout = r_vram_dout;
    assign o_rd_buf    = r_rd_buf;
    assign o_busy      = r_busy;
    assign o_state     = r_state;

endmodule

// File: rtl/vdp_cpu_port.sv
// CPU-side front end of the TMS9918-compatible VDP: port decode, register
// file, status/interrupt logic, and the VRAM access sequencer.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
)
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              io_wr,
    input  logic              io_rd,
    input  logic              io_port,
    input  logic [7:0]        io_din,
    output logic [7:0]        io_dout,
    output logic              io_wait,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic              vram_rd,
    output logic [7:0]        vram_dout,
    input  logic [7:0]        vram_din,
    input  logic              frame_int,
    input  logic              sprite_collision,
    input  logic              too_many_sprites,
    input  logic [4:0]        sprite5,
    output logic [1:0]        mode,
    output logic              video_on,
    output logic              vert_retrace_int,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       color_table_addr,
    output logic [13:0]       font_addr,
    output logic [13:0]       sprite_attr_addr,
    output logic [13:0]       sprite_pattern_table_addr,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    output logic              n_int
);

    logic [7:0] r_regs [NUM_REGS];
    logic       r_latch;
    logic [7:0] r_low;
    logic [7:0] r_io_dout;
    logic       r_st_f;
    logic       r_st_5s;
    logic       r_st_c;
    logic [4:0] r_sprite5;
    logic       r_n_int;

    logic              w_busy;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ctl_wr;
    logic              w_data_wr;
    logic              w_data_rd;
    logic              w_stat_rd;
    logic              w_second;
    logic              w_reg_wr;
    logic              w_load_addr;
    logic              w_start_rd;
    logic [ADDR_W-1:0] w_load_val;
    logic [7:0]        w_rd_buf;
    logic [7:0]        w_status;
    logic              w_f_next;
    logic              w_vri_next;
    logic [1:0]        w_acc_state;
    logic              w_unused;

    // Strobes landing while an access is in flight are discarded with no side effects.
    assign w_wr_acc    = io_wr & ~w_busy;
    assign w_rd_acc    = io_rd & ~io_wr & ~w_busy;
    assign w_ctl_wr    = w_wr_acc & io_port;
    assign w_data_wr   = w_wr_acc & ~io_port;
    assign w_stat_rd   = w_rd_acc & io_port;
    assign w_data_rd   = w_rd_acc & ~io_port;
    assign w_second    = w_ctl_wr & r_latch;
    assign w_reg_wr    = w_second & io_din[CTL_REG_BIT];
    assign w_load_addr = w_second & ((io_din[7:6] == CTL_OP_VRAM_RD) | (io_din[7:6] == CTL_OP_VRAM_WR));
    assign w_start_rd  = (w_load_addr & (io_din[7:6] == CTL_OP_VRAM_RD)) | w_data_rd;
    assign w_load_val  = ADDR_W'({io_din[5:0], r_low});

    always_comb begin
        w_status        = '0;
        w_status[ST_F]  = r_st_f;
        w_status[ST_5S] = r_st_5s;
        w_status[ST_C]  = r_st_c;
        w_status[4:0]   = r_sprite5;
    end

    // A same-cycle set beats the status-read clear.
    assign w_f_next   = frame_int | (r_st_f & ~w_stat_rd);
    assign w_vri_next = (w_reg_wr && (io_din[2:0] == R1)) ? r_low[5] : r_regs[R1][5];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_wr) begin
            r_regs[io_din[2:0]] <= r_low;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_latch   <= 1'b0;
            r_low     <= '0;
            r_io_dout <= '0;
            r_st_f    <= 1'b0;
            r_st_5s   <= 1'b0;
            r_st_c    <= 1'b0;
            r_sprite5 <= '0;
            r_n_int   <= 1'b1;
        end else begin
            if (w_ctl_wr) begin
                if (!r_latch) begin
                    r_low <= io_din;
                end
                r_latch <= ~r_latch;
            end else if (w_data_wr | w_data_rd | w_stat_rd) begin
                r_latch <= 1'b0;
            end
            if (w_data_rd) begin
                r_io_dout <= w_rd_buf;
            end else if (w_stat_rd) begin
                r_io_dout <= w_status;
            end
            r_st_f  <= w_f_next;
            r_st_c  <= sprite_collision | (r_st_c & ~w_stat_rd);
            r_st_5s <= too_many_sprites | (r_st_5s & ~w_stat_rd);
            if (!r_st_5s) begin
                r_sprite5 <= sprite5;
            end
            r_n_int <= ~(w_f_next & w_vri_next);
        end
    end

    vdp_vram_access #(.ADDR_W(ADDR_W)) u_access (
        .clk         (clk),
        .n_reset     (n_reset),
        .i_start_rd  (w_start_rd),
        .i_start_wr  (w_data_wr),
        .i_load_addr (w_load_addr),
        .i_load_val  (w_load_val),
        .i_wr_data   (io_din),
        .i_vram_din  (vram_din),
        .o_vram_addr (vram_addr),
        .o_vram_wr   (vram_wr),
        .o_vram_rd   (vram_rd),
        .o_vram_dout (vram_dout),
        .o_rd_buf    (w_rd_buf),
        .o_busy      (w_busy),
        .o_state     (w_acc_state)
    );

    assign io_dout = r_io_dout;
    assign io_wait = w_busy;
    assign n_int   = r_n_int;

    assign mode = r_regs[R1][4] ? MODE_TEXT :
                  r_regs[R0][1] ? MODE_G2   :
                  r_regs[R1][3] ? MODE_MC   : MODE_G1;

    assign video_on         = r_regs[R1][6];
    assign vert_retrace_int = r_regs[R1][5];
    assign sprite_large     = r_regs[R1][1];
    assign sprite_enlarged  = r_regs[R1][0];

    assign name_table_addr           = {r_regs[R2][3:0], 10'b0};
    assign color_table_addr          = {r_regs[R3], 6'b0};
    assign font_addr                 = {r_regs[R4][2:0], 11'b0};
    assign sprite_attr_addr          = {r_regs[R5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {r_regs[R6][2:0], 11'b0};
    assign text_color                = r_regs[R7][7:4];
    assign back_color                = r_regs[R7][3:0];

    // Register bits with no decoded meaning on this chip.
    assign w_unused = ^{r_regs[R0][7:2], r_regs[R0][0], r_regs[R1][7], r_regs[R1][2],
                        r_regs[R2][7:4], r_regs[R4][7:3], r_regs[R5][7], r_regs[R6][7:3],
                        w_acc_state};

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: register table, hand sequences, and randomized ops
// against a behavioural VDP model with a VRAM strobe scoreboard.
module tb_vdp_cpu_port;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              n_reset;
    logic              io_wr, io_rd, io_port;
    logic [7:0]        io_din, io_dout;
    logic              io_wait;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_wr, vram_rd;
    logic [7:0]        vram_dout, vram_din;
    logic              frame_int, sprite_collision, too_many_sprites;
    logic [4:0]        sprite5;
    logic [1:0]        mode;
    logic              video_on, vert_retrace_int, sprite_large, sprite_enlarged;
    logic [13:0]       name_table_addr, color_table_addr, font_addr;
    logic [13:0]       sprite_attr_addr, sprite_pattern_table_addr;
    logic [3:0]        text_color, back_color;
    logic              n_int;

    vdp_cpu_port #(.ADDR_W(ADDR_W), .NUM_REGS(8)) dut (
        .clk(clk), .n_reset(n_reset), .io_wr(io_wr), .io_rd(io_rd), .io_port(io_port),
        .io_din(io_din), .io_dout(io_dout), .io_wait(io_wait), .vram_addr(vram_addr),
        .vram_wr(vram_wr), .vram_rd(vram_rd), .vram_dout(vram_dout), .vram_din(vram_din),
        .frame_int(frame_int), .sprite_collision(sprite_collision),
        .too_many_sprites(too_many_sprites), .sprite5(sprite5), .mode(mode),
        .video_on(video_on), .vert_retrace_int(vert_retrace_int),
        .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
        .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
        .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
        .sprite_pattern_table_addr(sprite_pattern_table_addr),
        .text_color(text_color), .back_color(back_color), .n_int(n_int)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- VRAM responder + scoreboard ----------------
    logic [7:0]  vram_mem [DEPTH];
    logic [7:0]  exp_vram [DEPTH];
    logic [21:0] exp_wr_q [$];
    logic [13:0] exp_rd_q [$];
    logic        rd_pend;
    logic [7:0]  rd_data;
    int          n_wr_seen = 0;
    int          n_rd_seen = 0;

    always @(negedge clk) begin
        if (!n_reset) begin
            rd_pend = 1'b0;
        end else begin
            vram_din = rd_pend ? rd_data : 8'($urandom);
            rd_pend  = 1'b0;
            if (vram_rd) begin
                n_rd_seen++;
                check("vram_rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
                if (exp_rd_q.size() != 0) check("vram_rd_addr", vram_addr, exp_rd_q.pop_front());
                rd_pend = 1'b1;
                rd_data = vram_mem[vram_addr];
            end
            if (vram_wr) begin
                n_wr_seen++;
                check("vram_wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) check("vram_wr_addr_data", {vram_addr, vram_dout}, exp_wr_q.pop_front());
                vram_mem[vram_addr] = vram_dout;
            end
        end
    end

    // ---------------- behavioural model ----------------
    logic [7:0]  m_regs [8];
    logic [13:0] m_addr;
    logic [7:0]  m_buf, m_low;
    logic        m_latch, m_f, m_5s, m_c;
    logic [4:0]  m_s5, m_s5_in;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_addr = '0; m_buf = 8'h00; m_low = 8'h00; m_latch = 1'b0;
        m_f = 1'b0; m_5s = 1'b0; m_c = 1'b0; m_s5 = m_s5_in;
    endtask

    task automatic prefetch();
        exp_rd_q.push_back(m_addr);
        m_buf  = exp_vram[m_addr];
        m_addr = m_addr + 14'd1;
    endtask

    function automatic logic [1:0] exp_mode();
        if (m_regs[1][4]) return 2'd0;
        if (m_regs[0][1]) return 2'd2;
        if (m_regs[1][3]) return 2'd3;
        return 2'd1;
    endfunction

    task automatic check_decode();
        check("mode", mode, exp_mode());
        check("name_table", name_table_addr, 32'(m_regs[2][3:0]) * 1024);
        check("color_table", color_table_addr, 32'(m_regs[3]) * 64);
        check("font", font_addr, 32'(m_regs[4][2:0]) * 2048);
        check("sprite_attr", sprite_attr_addr, 32'(m_regs[5][6:0]) * 128);
        check("sprite_pat", sprite_pattern_table_addr, 32'(m_regs[6][2:0]) * 2048);
        check("colors", {text_color, back_color}, m_regs[7]);
        check("r1_bits", {video_on, vert_retrace_int, sprite_large, sprite_enlarged},
              {m_regs[1][6], m_regs[1][5], m_regs[1][1], m_regs[1][0]});
        check("n_int", n_int, !(m_f && m_regs[1][5]));
        check("vram_addr", vram_addr, m_addr);
        check("io_wait_idle", io_wait, 1'b0);
    endtask

    // ---------------- drivers ----------------
    task automatic wait_idle();
        int cnt = 0;
        while (io_wait && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("wait_budget", 32'(cnt < 20), 32'd1);
    endtask

    task automatic do_strobe(input logic wr, input logic port, input logic [7:0] din,
                             input logic frame, output logic [7:0] dout);
        @(negedge clk);
        io_wr = wr; io_rd = !wr; io_port = port; io_din = din; frame_int = frame;
        @(negedge clk);
        io_wr = 1'b0; io_rd = 1'b0; frame_int = 1'b0;
        dout = io_dout;
        wait_idle();
    endtask

    task automatic ctl_wr(input logic [7:0] b);
        logic [7:0] d;
        if (!m_latch) begin
            m_low = b; m_latch = 1'b1;
        end else begin
            m_latch = 1'b0;
            if (b[7]) m_regs[b[2:0]] = m_low;
            else begin
                m_addr = {b[5:0], m_low};
                if (!b[6]) prefetch();
            end
        end
        do_strobe(1'b1, 1'b1, b, 1'b0, d);
    endtask

    task automatic dat_wr(input logic [7:0] b);
        logic [7:0] d;
        m_latch = 1'b0;
        exp_wr_q.push_back({m_addr, b});
        exp_vram[m_addr] = b;
        m_buf  = b;
        m_addr = m_addr + 14'd1;
        do_strobe(1'b1, 1'b0, b, 1'b0, d);
    endtask

    task automatic dat_rd(output logic [7:0] dout);
        logic [7:0] e;
        e = m_buf;
        m_latch = 1'b0;
        prefetch();
        do_strobe(1'b0, 1'b0, 8'h00, 1'b0, dout);
        check("data_read", dout, e);
    endtask

    task automatic st_rd(input logic frame, output logic [7:0] dout);
        logic [7:0] e;
        e = {m_f, m_5s, m_c, m_s5};
        do_strobe(1'b0, 1'b1, 8'h00, frame, dout);
        check("status_read", dout, e);
        m_f = frame; m_5s = 1'b0; m_c = 1'b0; m_s5 = m_s5_in; m_latch = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk); frame_int = 1'b1;
        @(negedge clk); frame_int = 1'b0;
        m_f = 1'b1;
    endtask

    task automatic set_sprite(input logic c, input logic t, input logic [4:0] s);
        @(negedge clk); sprite_collision = c; too_many_sprites = t; sprite5 = s;
        @(negedge clk); sprite_collision = 1'b0; too_many_sprites = 1'b0;
        m_c = m_c | c;
        if (!m_5s) m_s5 = s;
        m_5s = m_5s | t;
        m_s5_in = s;
    endtask

    // ---------------- register table ----------------
    typedef struct {
        logic [2:0]  ridx;
        logic [7:0]  val;
        logic [1:0]  mode;
        logic [13:0] tbl;
        logic [3:0]  r1b;
    } vec_t;
    vec_t vecs [20];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [7:0]  d;
        logic [31:0] act;
        int          w0, r0;

        vecs[0]  = '{3'd0, 8'h00, 2'd1, 14'h0000, 4'h0};
        vecs[1]  = '{3'd0, 8'h02, 2'd2, 14'h0000, 4'h0};
        vecs[2]  = '{3'd1, 8'h08, 2'd2, 14'h0000, 4'h0};
        vecs[3]  = '{3'd1, 8'h18, 2'd0, 14'h0000, 4'h0};
        vecs[4]  = '{3'd0, 8'h00, 2'd0, 14'h0000, 4'h0};
        vecs[5]  = '{3'd1, 8'h08, 2'd3, 14'h0000, 4'h0};
        vecs[6]  = '{3'd1, 8'h63, 2'd1, 14'h0000, 4'hF};
        vecs[7]  = '{3'd1, 8'h40, 2'd1, 14'h0000, 4'h8};
        vecs[8]  = '{3'd2, 8'hFF, 2'd1, 14'h3C00, 4'h8};
        vecs[9]  = '{3'd2, 8'h05, 2'd1, 14'h1400, 4'h8};
        vecs[10] = '{3'd3, 8'hFF, 2'd1, 14'h3FC0, 4'h8};
        vecs[11] = '{3'd3, 8'h81, 2'd1, 14'h2040, 4'h8};
        vecs[12] = '{3'd4, 8'hFF, 2'd1, 14'h3800, 4'h8};
        vecs[13] = '{3'd4, 8'h02, 2'd1, 14'h1000, 4'h8};
        vecs[14] = '{3'd5, 8'hFF, 2'd1, 14'h3F80, 4'h8};
        vecs[15] = '{3'd5, 8'h36, 2'd1, 14'h1B00, 4'h8};
        vecs[16] = '{3'd6, 8'hFF, 2'd1, 14'h3800, 4'h8};
        vecs[17] = '{3'd6, 8'h05, 2'd1, 14'h2800, 4'h8};
        vecs[18] = '{3'd7, 8'hF4, 2'd1, 14'h00F4, 4'h8};
        vecs[19] = '{3'd7, 8'h1E, 2'd1, 14'h001E, 4'h8};

        for (int i = 0; i < DEPTH; i++) begin
            vram_mem[i] = 8'(i * 37 + 5);
            exp_vram[i] = 8'(i * 37 + 5);
        end
        n_reset = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_port = 1'b0; io_din = 8'h00;
        frame_int = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0; sprite5 = 5'd0;
        vram_din = 8'h00; rd_pend = 1'b0; m_s5_in = 5'd0;
        model_reset();
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_io_dout", io_dout, 8'h00);
        check("rst_io_wait", io_wait, 1'b0);
        check("rst_vram_wr", vram_wr, 1'b0);
        check("rst_vram_rd", vram_rd, 1'b0);
        check("rst_n_int", n_int, 1'b1);
        check("rst_mode", mode, 2'd1);
        check("rst_video_on", video_on, 1'b0);
        check("rst_tables", {name_table_addr, color_table_addr, font_addr}, 42'h0);
        check_decode();

        // Register table
        for (int i = 0; i < 20; i++) begin
            ctl_wr(vecs[i].val);
            ctl_wr(8'h80 | 8'(vecs[i].ridx));
            check("vec_mode", mode, vecs[i].mode);
            case (vecs[i].ridx)
                3'd2: act = 32'(name_table_addr);
                3'd3: act = 32'(color_table_addr);
                3'd4: act = 32'(font_addr);
                3'd5: act = 32'(sprite_attr_addr);
                3'd6: act = 32'(sprite_pattern_table_addr);
                3'd7: act = 32'({text_color, back_color});
                default: act = 32'(vecs[i].tbl);
            endcase
            check("vec_table", act, vecs[i].tbl);
            check("vec_r1", {video_on, vert_retrace_int, sprite_large, sprite_enlarged}, vecs[i].r1b);
            check_decode();
        end

        // Colour register; no VRAM traffic
        w0 = n_wr_seen; r0 = n_rd_seen;
        ctl_wr(8'h00); ctl_wr(8'h87);
        check("r7_zero", {text_color, back_color}, 8'h00);
        ctl_wr(8'hF4); ctl_wr(8'h87);
        check("text_color", text_color, 4'hF);
        check("back_color", back_color, 4'h4);
        check("no_strobes_regwr", n_wr_seen + n_rd_seen, w0 + r0);

        // Data writes
        w0 = n_wr_seen;
        ctl_wr(8'h00); ctl_wr(8'h40);
        dat_wr(8'hAA); dat_wr(8'hBB);
        check("vram0", vram_mem[0], 8'hAA);
        check("vram1", vram_mem[1], 8'hBB);
        check("addr_after_wr", vram_addr, 14'd2);
        check("wr_strobe_count", n_wr_seen - w0, 2);
        check_decode();

        // Read-ahead across the address wrap
        vram_mem[14'h3FFF] = 8'h11; exp_vram[14'h3FFF] = 8'h11;
        vram_mem[0] = 8'h22; exp_vram[0] = 8'h22;
        r0 = n_rd_seen;
        ctl_wr(8'hFF); ctl_wr(8'h3F);
        dat_rd(d); check("read_3fff", d, 8'h11);
        dat_rd(d); check("read_wrap", d, 8'h22);
        check("rd_strobe_count", n_rd_seen - r0, 3);
        check_decode();

        // Mode priority
        ctl_wr(8'h02); ctl_wr(8'h80);
        ctl_wr(8'h10); ctl_wr(8'h81);
        check("mode_text", mode, 2'd0);
        ctl_wr(8'h00); ctl_wr(8'h81);
        check("mode_g2", mode, 2'd2);

        // Interrupt and status
        ctl_wr(8'h20); ctl_wr(8'h81);
        pulse_frame();
        check("n_int_asserted", n_int, 1'b0);
        st_rd(1'b0, d);
        check("status_f_set", d[7], 1'b1);
        check("n_int_released", n_int, 1'b1);
        st_rd(1'b1, d);
        check("status_f_clear", d[7], 1'b0);
        check("n_int_set_wins", n_int, 1'b0);
        st_rd(1'b0, d);
        check("status_f_kept", d[7], 1'b1);
        set_sprite(1'b1, 1'b1, 5'd9);
        set_sprite(1'b0, 1'b0, 5'd3);
        st_rd(1'b0, d);
        check("status_sprite", d, 8'h69);
        check_decode();

        // Status read resets the byte latch
        ctl_wr(8'h34);
        st_rd(1'b0, d);
        ctl_wr(8'h00); ctl_wr(8'h81);
        check("r1_latch_reset", {video_on, vert_retrace_int, sprite_large, sprite_enlarged}, 4'h0);
        check_decode();

        // Strobes during a busy read are dropped
        d = m_buf;
        m_latch = 1'b0;
        prefetch();
        @(negedge clk); io_rd = 1'b1; io_port = 1'b0;
        @(negedge clk); io_rd = 1'b0;
        check("busy_rd_dout", io_dout, d);
        check("busy_1", io_wait, 1'b1);
        io_wr = 1'b1; io_port = 1'b1; io_din = 8'h85;
        @(negedge clk);
        check("busy_2", io_wait, 1'b1);
        io_port = 1'b0; io_din = 8'h77;
        @(negedge clk); io_wr = 1'b0;
        wait_idle();
        check_decode();
        ctl_wr(8'h12); ctl_wr(8'h87);
        check("after_drop_colors", {text_color, back_color}, 8'h12);

        // Randomized operations against the model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 6))
                0, 1: ctl_wr(8'($urandom_range(0, 255)));
                2:    dat_wr(8'($urandom_range(0, 255)));
                3:    dat_rd(d);
                4:    st_rd(1'($urandom_range(0, 3) == 0), d);
                5:    set_sprite(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
                default: pulse_frame();
            endcase
            check_decode();
        end

        // Reset in the middle of a read access
        @(negedge clk); io_rd = 1'b1; io_port = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_rd_seen", vram_rd, 1'b1);
        n_reset = 1'b0; io_rd = 1'b0;
        #1;
        check("mid_rst_vram_rd", vram_rd, 1'b0);
        check("mid_rst_io_wait", io_wait, 1'b0);
        exp_rd_q.delete();
        exp_wr_q.delete();
        @(negedge clk); n_reset = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        check_decode();

        check("wr_q_empty", exp_wr_q.size(), 0);
        check("rd_q_empty", exp_rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
